// File: rtl/mips_pkg.sv
// Shared MIPS definitions: opcode constants, instruction field positions and
// a decode-flag helper reused by the IR and the control unit.
package mips_pkg;

   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_J     = 6'h02;
   localparam logic [5:0] OP_JAL   = 6'h03;
   localparam logic [5:0] OP_BEQ   = 6'h04;
   localparam logic [5:0] OP_BNE   = 6'h05;
   localparam logic [5:0] OP_LW    = 6'h23;
   localparam logic [5:0] OP_SW    = 6'h2B;

   localparam int OPCODE_MSB = 31;
   localparam int OPCODE_LSB = 26;
   localparam int RS_MSB     = 25;
   localparam int RS_LSB     = 21;
   localparam int RT_MSB     = 20;
   localparam int RT_LSB     = 16;
   localparam int RD_MSB     = 15;
   localparam int RD_LSB     = 11;
   localparam int SHAMT_MSB  = 10;
   localparam int SHAMT_LSB  = 6;
   localparam int FUNCT_MSB  = 5;
   localparam int FUNCT_LSB  = 0;
   localparam int IMM_MSB    = 15;
   localparam int IMM_LSB    = 0;
   localparam int JADDR_MSB  = 25;
   localparam int JADDR_LSB  = 0;

   typedef struct packed {
      logic is_rtype;
      logic is_jump;
      logic is_branch;
      logic is_load;
      logic is_store;
   } ir_flags_t;

   // Each opcode maps to at most one class, so the flags are one-hot or zero.
   function automatic ir_flags_t decode_flags(input logic [5:0] op);
      ir_flags_t f;
      f = '0;
      case (op)
         OP_RTYPE:      f.is_rtype  = 1'b1;
         OP_J, OP_JAL:  f.is_jump   = 1'b1;
         OP_BEQ, OP_BNE: f.is_branch = 1'b1;
         OP_LW:         f.is_load   = 1'b1;
         OP_SW:         f.is_store  = 1'b1;
         default:       f = '0;
      endcase
      return f;
   endfunction

endpackage

// File: rtl/ir_decode.sv
// Combinational slicer for a stored MIPS word: fields, immediate extensions
// and instruction-class flags. Fields overlap by design and are always driven.
module ir_decode
   import mips_pkg::*;
(
   input  logic [31:0] ir_q,
   output logic [5:0]  opcode,
   output logic [4:0]  rs,
   output logic [4:0]  rt,
   output logic [4:0]  rd,
   output logic [4:0]  shamt,
   output logic [5:0]  funct,
   output logic [15:0] immediate,
   output logic [25:0] jumpAddress,
   output logic [31:0] imm_sext,
   output logic [31:0] imm_zext,
   output logic        is_rtype,
   output logic        is_jump,
   output logic        is_branch,
   output logic        is_load,
   output logic        is_store
);

   ir_flags_t flags;

   assign opcode      = ir_q[OPCODE_MSB:OPCODE_LSB];
   assign rs          = ir_q[RS_MSB:RS_LSB];
   assign rt          = ir_q[RT_MSB:RT_LSB];
   assign rd          = ir_q[RD_MSB:RD_LSB];
   assign shamt       = ir_q[SHAMT_MSB:SHAMT_LSB];
   assign funct       = ir_q[FUNCT_MSB:FUNCT_LSB];
   assign immediate   = ir_q[IMM_MSB:IMM_LSB];
   assign jumpAddress = ir_q[JADDR_MSB:JADDR_LSB];

   assign imm_sext = {{16{ir_q[IMM_MSB]}}, ir_q[IMM_MSB:IMM_LSB]};
   assign imm_zext = {16'h0000, ir_q[IMM_MSB:IMM_LSB]};

   assign flags     = decode_flags(ir_q[OPCODE_MSB:OPCODE_LSB]);
   assign is_rtype  = flags.is_rtype;
   assign is_jump   = flags.is_jump;
   assign is_branch = flags.is_branch;
   assign is_load   = flags.is_load;
   assign is_store  = flags.is_store;

endmodule

// File: rtl/reg_instruccion.sv
// Instruction register of the multicycle datapath: captures the fetched word
// on ir_w and exposes its decoded view to the rest of the datapath.
module reg_instruccion
   import mips_pkg::*;
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic [31:0] instruction,
   input  logic        ir_w,
   output logic [5:0]  opcode,
   output logic [4:0]  rs,
   output logic [4:0]  rt,
   output logic [4:0]  rd,
   output logic [4:0]  shamt,
   output logic [5:0]  funct,
   output logic [15:0] immediate,
   output logic [25:0] jumpAddress,
   output logic [31:0] imm_sext,
   output logic [31:0] imm_zext,
   output logic [31:0] instr_q,
   output logic        is_rtype,
   output logic        is_jump,
   output logic        is_branch,
   output logic        is_load,
   output logic        is_store
);

   logic [31:0] ir_q;

   // NOTE: non-blocking assignment keeps the capture race-free against
   // readers of ir_q clocked on the same edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         ir_q <= 32'h0000_0000;
      else if (ir_w)
         ir_q <= instruction;
   end

   assign instr_q = ir_q;

   ir_decode u_ir_decode (
      .ir_q        (ir_q),
      .opcode      (opcode),
      .rs          (rs),
      .rt          (rt),
      .rd          (rd),
      .shamt       (shamt),
      .funct       (funct),
      .immediate   (immediate),
      .jumpAddress (jumpAddress),
      .imm_sext    (imm_sext),
      .imm_zext    (imm_zext),
      .is_rtype    (is_rtype),
      .is_jump     (is_jump),
      .is_branch   (is_branch),
      .is_load     (is_load),
      .is_store    (is_store)
   );

endmodule

// File: tb/tb_reg_instruccion.sv
// Bench for reg_instruccion: directed test-plan sequence plus randomized
// writes checked against an arithmetic model of the stored word.
module tb_reg_instruccion;

   logic        clk;
   logic        rst_n;
   logic [31:0] instruction;
   logic        ir_w;
   logic [5:0]  opcode;
   logic [4:0]  rs, rt, rd, shamt;
   logic [5:0]  funct;
   logic [15:0] immediate;
   logic [25:0] jumpAddress;
   logic [31:0] imm_sext, imm_zext, instr_q;
   logic        is_rtype, is_jump, is_branch, is_load, is_store;

   int checks;
   int errors;
   logic [31:0] model_q;

   reg_instruccion dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .instruction (instruction),
      .ir_w        (ir_w),
      .opcode      (opcode),
      .rs          (rs),
      .rt          (rt),
      .rd          (rd),
      .shamt       (shamt),
      .funct       (funct),
      .immediate   (immediate),
      .jumpAddress (jumpAddress),
      .imm_sext    (imm_sext),
      .imm_zext    (imm_zext),
      .instr_q     (instr_q),
      .is_rtype    (is_rtype),
      .is_jump     (is_jump),
      .is_branch   (is_branch),
      .is_load     (is_load),
      .is_store    (is_store)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, act, exp);
      end
   endtask

   // Expected outputs derived from the word with shifts and modulo arithmetic.
   task automatic check_word(input string tag, input logic [31:0] w);
      int unsigned u, op, imm;
      logic [31:0] sext;
      u    = w;
      op   = u >> 26;
      imm  = u % 65536;
      sext = (imm >= 32768) ? (imm + 32'hFFFF_0000) : imm;
      check({tag, ".instr_q"},   instr_q,                w);
      check({tag, ".opcode"},    32'(opcode),            op);
      check({tag, ".rs"},        32'(rs),                (u >> 21) % 32);
      check({tag, ".rt"},        32'(rt),                (u >> 16) % 32);
      check({tag, ".rd"},        32'(rd),                (u >> 11) % 32);
      check({tag, ".shamt"},     32'(shamt),             (u >> 6) % 32);
      check({tag, ".funct"},     32'(funct),             u % 64);
      check({tag, ".immediate"}, 32'(immediate),         imm);
      check({tag, ".jaddr"},     32'(jumpAddress),       u % 67108864);
      check({tag, ".imm_sext"},  imm_sext,               sext);
      check({tag, ".imm_zext"},  imm_zext,               imm);
      check({tag, ".is_rtype"},  32'(is_rtype),          32'(op == 0));
      check({tag, ".is_jump"},   32'(is_jump),           32'(op == 2 || op == 3));
      check({tag, ".is_branch"}, 32'(is_branch),         32'(op == 4 || op == 5));
      check({tag, ".is_load"},   32'(is_load),           32'(op == 35));
      check({tag, ".is_store"},  32'(is_store),          32'(op == 43));
   endtask

   task automatic cycle(input string tag, input logic [31:0] w, input logic we);
      @(negedge clk);
      instruction = w;
      ir_w        = we;
      @(posedge clk);
      if (we) model_q = w;
      #1;
      check_word(tag, model_q);
   endtask

   initial begin
      logic [31:0] word;
      logic [5:0]  ops [8];
      checks      = 0;
      errors      = 0;
      model_q     = 32'h0;
      rst_n       = 1'b0;
      ir_w        = 1'b0;
      instruction = 32'h0;
      ops = '{6'h00, 6'h02, 6'h03, 6'h04, 6'h05, 6'h23, 6'h2B, 6'h3F};

      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      cycle("preload", 32'hFFFF_FFFF, 1'b1);

      // Reset mid-cycle, no clock edge, ir_w and instruction still active.
      #3 rst_n = 1'b0;
      model_q = 32'h0;
      #1;
      check_word("reset_async", model_q);
      check("reset_is_rtype", 32'(is_rtype), 32'd1);
      @(posedge clk);
      #1;
      check_word("reset_priority", model_q);
      @(negedge clk);
      rst_n = 1'b1;

      cycle("rtype", 32'h0030_0020, 1'b1);
      check("rtype.rs", 32'(rs), 32'd1);
      check("rtype.rt", 32'(rt), 32'd16);
      check("rtype.funct", 32'(funct), 32'h20);
      check("rtype.jaddr", 32'(jumpAddress), 32'h030_0020);
      check("rtype.flag", 32'(is_rtype), 32'd1);

      cycle("beq", 32'h1000_0030, 1'b1);
      check("beq.opcode", 32'(opcode), 32'h04);
      check("beq.imm_sext", imm_sext, 32'h0000_0030);
      check("beq.flags", {27'd0, is_rtype, is_jump, is_branch, is_load, is_store}, 32'b00100);

      for (int i = 0; i < 3; i++) cycle("hold", 32'hDEAD_BEEF, 1'b0);
      check("hold.instr_q", instr_q, 32'h1000_0030);

      cycle("lw", 32'h8C22_FFFC, 1'b1);
      check("lw.imm_sext", imm_sext, 32'hFFFF_FFFC);
      check("lw.imm_zext", imm_zext, 32'h0000_FFFC);
      check("lw.is_load", 32'(is_load), 32'd1);
      check("lw.rs_rt", {22'd0, rs, rt}, {22'd0, 5'd1, 5'd2});

      cycle("j", 32'h0810_0004, 1'b1);
      check("j.jaddr", 32'(jumpAddress), 32'h010_0004);
      check("j.is_jump", 32'(is_jump), 32'd1);

      for (int i = 0; i < 4; i++) begin
         word = $urandom;
         cycle("b2b", word, 1'b1);
         check("b2b.instr_q", instr_q, word);
      end

      for (int i = 0; i < 300; i++) begin
         word = $urandom;
         if ($urandom_range(0, 1) == 1) word[31:26] = ops[$urandom_range(0, 7)];
         cycle("rand", word, 1'($urandom_range(0, 2) != 0));
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/reg_instruccion.md
# reg_instruccion

Instruction register (IR) for the multicycle MIPS-style datapath. It captures the 32-bit word fetched from memory when the control unit asserts `ir_w`, and holds it until the next write. It exposes the standard MIPS fields plus a small set of pre-decoded helpers to the register file, ALU control, sign-extender and jump logic. It sits between instruction memory and the decode/control stage.

## Interface
- No parameters; all widths fixed for a 32-bit MIPS word.
- `clk` input 1: system clock; rising-edge active.
- `rst_n` input 1: asynchronous, active-low reset.
- `instruction` input 32: word from instruction memory.
- `ir_w` input 1: IR write enable from the control unit.
- `opcode` output 6: bits [31:26].
- `rs` output 5: bits [25:21].
- `rt` output 5: bits [20:16].
- `rd` output 5: bits [15:11].
- `shamt` output 5: bits [10:6].
- `funct` output 6: bits [5:0].
- `immediate` output 16: bits [15:0].
- `jumpAddress` output 26: bits [25:0].
- `imm_sext` output 32: `immediate` sign-extended.
- `imm_zext` output 32: `immediate` zero-extended.
- `instr_q` output 32: raw stored word.
- `is_rtype` output 1: opcode == 6'h00.
- `is_jump` output 1: opcode is 6'h02 (j) or 6'h03 (jal).
- `is_branch` output 1: opcode is 6'h04 (beq) or 6'h05 (bne).
- `is_load` output 1: opcode == 6'h23 (lw).
- `is_store` output 1: opcode == 6'h2B (sw).

## Operation
- Single 32-bit storage register `ir_q`.
- On each rising `clk` with `ir_w`=1: `ir_q` <= `instruction`.
- On each rising `clk` with `ir_w`=0: `ir_q` holds its value.
- All outputs are purely combinational slices or decodes of `ir_q`. No output depends directly on `instruction`.
- Field overlap is intentional.
  - `rd`, `shamt`, `funct` and `immediate` share bits.
  - `jumpAddress` contains `rs`, `rt` and `immediate`.
- Every field is always driven, regardless of instruction format.
- `imm_sext` = {16{ir_q[15]}, ir_q[15:0]}.
- `imm_zext` = {16'h0000, ir_q[15:0]}.
- The decode flags are mutually exclusive. All flags are 0 for any opcode not listed above.

## Timing
- Asynchronous reset: `rst_n`=0 forces `ir_q`=32'h0000_0000 immediately, independent of `clk`.
- Reset takes priority over `ir_w`.
- Output values during reset:
  - All fields 0; `imm_sext` and `imm_zext` 0.
  - `is_rtype`=1, because opcode 0 is a NOP/sll. All other flags 0.
- Release of `rst_n` is expected to be synchronous to `clk`. The first capture occurs at the first rising edge with `rst_n`=1 and `ir_w`=1.
- Latency: outputs reflect a written word in the same delta after the capturing edge, i.e. one cycle after `instruction` is presented with `ir_w`.
- `ir_w` held high across consecutive edges: each edge loads the current `instruction`; the last write wins.
- `instruction` changing while `ir_w`=0: no effect.
- `instruction` and `ir_w` must be stable around the rising edge. The bench drives them on the falling edge.

## Structure
- Shared package `mips_pkg` holds:
  - Opcode constants: OP_RTYPE=6'h00, OP_J=6'h02, OP_JAL=6'h03, OP_BEQ=6'h04, OP_BNE=6'h05, OP_LW=6'h23, OP_SW=6'h2B.
  - Field bit-position constants.
- One natural sub-module: `ir_decode`. It is the combinational slicer, extender and flag generator driven by `ir_q`. It is reusable by the control unit.
- The top module contains only the register and the instance.

## Test plan
- Reset: assert `rst_n`=0 mid-cycle with `ir_w`=1 and `instruction`=32'hFFFF_FFFF.
  - All fields and extensions go to 0 without a clock edge.
  - `is_rtype`=1.
- R-type load: `ir_w`=1, `instruction`=32'h0030_0020, one rising edge. Required values:
  - `opcode`=0, `rs`=1, `rt`=16, `rd`=0, `shamt`=0, `funct`=6'h20.
  - `immediate`=16'h0020, `jumpAddress`=26'h030_0020.
  - `is_rtype`=1.
- Branch load: next edge with `ir_w`=1, `instruction`=32'h1000_0030. Required values:
  - `opcode`=6'h04, `rs`=0, `rt`=0, `immediate`=16'h0030.
  - `imm_sext`=32'h0000_0030.
  - `is_branch`=1, `is_rtype`=0.
- Hold: `ir_w`=0, `instruction`=32'hDEAD_BEEF for 3 edges. All outputs keep the beq values.
- Sign extension and jump:
  - Load 32'h8C22_FFFC (lw): `imm_sext`=32'hFFFF_FFFC, `imm_zext`=32'h0000_FFFC, `is_load`=1, `rs`=1, `rt`=2.
  - Then load 32'h0810_0004 (j): `jumpAddress`=26'h010_0004, `is_jump`=1.
- Back-to-back writes: change `instruction` every cycle with `ir_w`=1 over 4 edges. After each edge `instr_q` equals the word present at that edge.
